writeback_stage: RTL and testbench

- Parametrised successor of the single-cycle writeback mux.
- Adds the MEM/WB pipeline register with stall/flush, and load-data extraction with sign/zero extension for byte, half and word loads (double-word loads when XLEN=64).
- Adds a fourth result source (CSR read data), x0 write suppression, and a retired-instruction counter with a retire pulse.
- Sits between the memory stage and the register file write port. Its result also feeds the forwarding network.

---
 rtl/writeback_stage_pkg.sv | 33 +++
 rtl/writeback_stage_load_extend.sv | 44 ++++
 rtl/writeback_stage.sv | 113 +++++++++++
 tb/tb_writeback_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings and the W pipeline record used by the writeback stage.
// Record data fields are sized for the widest legal datapath and narrowed at use.
package writeback_stage_pkg;

  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned REG_AW_MAX = 8;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;
  localparam logic [1:0] RESULT_CSR  = 2'b11;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [1:0]            resultsrc;
    logic [2:0]            funct3;
    logic [REG_AW_MAX-1:0] rd;
    logic [XLEN_MAX-1:0]   alu;
    logic [XLEN_MAX-1:0]   rdata;
    logic [XLEN_MAX-1:0]   pc4;
    logic [XLEN_MAX-1:0]   csr;
  } w_rec_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Load-data extraction: picks the byte/half/word at the byte offset and
// sign- or zero-extends it. Misaligned low offset bits are simply dropped.
module writeback_stage_load_extend
  import writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  ext_c
);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  always_comb begin
    off_h  = off & ~OFF_W'(1);
    off_w  = off & ~OFF_W'(3);
    byte_v = 8'(rdata >> {off, 3'b000});
    half_v = 16'(rdata >> {off_h, 3'b000});
    word_v = 32'(rdata >> {off_w, 3'b000});
  end

  // Word-sized codes that are only meaningful on a 64-bit datapath fall back to LW.
  always_comb begin
    ext_c = rdata;
    unique case (funct3)
      FUNCT3_LB:  ext_c = XLEN'($signed(byte_v));
      FUNCT3_LBU: ext_c = XLEN'(byte_v);
      FUNCT3_LH:  ext_c = XLEN'($signed(half_v));
      FUNCT3_LHU: ext_c = XLEN'(half_v);
      FUNCT3_LW:  ext_c = XLEN'($signed(word_v));
      FUNCT3_LWU: ext_c = (XLEN == 64) ? XLEN'(word_v) : XLEN'($signed(word_v));
      FUNCT3_LD:  ext_c = (XLEN == 64) ? rdata : XLEN'($signed(word_v));
      default:    ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register with stall/flush, result select, x0 write
// suppression and a retired-instruction counter with a one-cycle retire pulse.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   RdataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   CsrDataM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              StallW,
  input  logic              FlushW,
  output logic              ValidW,
  output logic              RegWriteW_out,
  output logic [REG_AW-1:0] RdW_out,
  output logic [XLEN-1:0]   ResultW,
  output logic              RetireW,
  output logic [CNT_W-1:0]  InstretW
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  w_rec_t           w_d, w_q;
  logic             fresh_d, fresh_q;
  logic [CNT_W-1:0] instret_d, instret_q;

  logic [XLEN-1:0]   alu_w, rdata_w, pc4_w, csr_w, load_w;
  logic [REG_AW-1:0] rd_w;

  // Next-state: flush beats stall beats capture.
  always_comb begin
    w_d       = w_q;
    fresh_d   = 1'b0;
    instret_d = instret_q;
    if (FlushW) begin
      w_d = '0;
    end else if (!StallW) begin
      w_d.valid     = ValidM;
      w_d.regwrite  = RegWriteM;
      w_d.resultsrc = ResultSrcM;
      w_d.funct3    = Funct3M;
      w_d.rd        = REG_AW_MAX'(RdM);
      w_d.alu       = XLEN_MAX'(ALUResultM);
      w_d.rdata     = XLEN_MAX'(RdataM);
      w_d.pc4       = XLEN_MAX'(PCPlus4M);
      w_d.csr       = XLEN_MAX'(CsrDataM);
      fresh_d       = ValidM;
      if (ValidM) begin
        instret_d = instret_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q       <= '0;
      fresh_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      w_q       <= w_d;
      fresh_q   <= fresh_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    alu_w   = XLEN'(w_q.alu);
    rdata_w = XLEN'(w_q.rdata);
    pc4_w   = XLEN'(w_q.pc4);
    csr_w   = XLEN'(w_q.csr);
    rd_w    = REG_AW'(w_q.rd);
  end

  writeback_stage_load_extend #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_extend (
    .funct3 (w_q.funct3),
    .off    (alu_w[OFF_W-1:0]),
    .rdata  (rdata_w),
    .ext_c  (load_w)
  );

  always_comb begin
    ResultW = alu_w;
    unique case (w_q.resultsrc)
      RESULT_ALU:  ResultW = alu_w;
      RESULT_LOAD: ResultW = load_w;
      RESULT_PC4:  ResultW = pc4_w;
      RESULT_CSR:  ResultW = csr_w;
      default:     ResultW = alu_w;
    endcase
  end

  always_comb begin
    ValidW        = w_q.valid;
    RegWriteW_out = w_q.regwrite & w_q.valid & (rd_w != '0);
    RdW_out       = rd_w;
    RetireW       = w_q.valid & fresh_q;
    InstretW      = instret_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, stall/flush
// and counter-wrap sequences, then random traffic against a behavioural model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, StallW, FlushW;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, RdataM, PCPlus4M, CsrDataM;
  logic [4:0]  RdM;

  logic        ValidW, RegWriteW_out, RetireW;
  logic [4:0]  RdW_out;
  logic [31:0] ResultW;
  logic [63:0] InstretW;

  logic        ValidW4, RegWriteW_out4, RetireW4;
  logic [4:0]  RdW_out4;
  logic [31:0] ResultW4;
  logic [3:0]  InstretW4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) u_dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .RdataM(RdataM), .PCPlus4M(PCPlus4M), .CsrDataM(CsrDataM), .RdM(RdM),
    .StallW(StallW), .FlushW(FlushW), .ValidW(ValidW),
    .RegWriteW_out(RegWriteW_out), .RdW_out(RdW_out), .ResultW(ResultW),
    .RetireW(RetireW), .InstretW(InstretW)
  );

  writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .RdataM(RdataM), .PCPlus4M(PCPlus4M), .CsrDataM(CsrDataM), .RdM(RdM),
    .StallW(StallW), .FlushW(FlushW), .ValidW(ValidW4),
    .RegWriteW_out(RegWriteW_out4), .RdW_out(RdW_out4), .ResultW(ResultW4),
    .RetireW(RetireW4), .InstretW(InstretW4)
  );

  // Behavioural model of what the W stage should hold.
  typedef struct {
    bit          valid, regwrite;
    bit [1:0]    src;
    bit [2:0]    f3;
    bit [4:0]    rd;
    bit [31:0]   alu, rdata, pc4, csr;
  } mrec_t;

  mrec_t       m;
  bit          m_fresh;
  longint unsigned m_cnt;

  function automatic bit [31:0] model_load(bit [2:0] f3, bit [31:0] addr, bit [31:0] rd);
    int unsigned off = addr % 4;
    bit [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic bit [31:0] model_result();
    case (m.src)
      2'd0: return m.alu;
      2'd1: return model_load(m.f3, m.alu, m.rdata);
      2'd2: return m.pc4;
      default: return m.csr;
    endcase
  endfunction

  task automatic model_update();
    if (reset) begin
      m = '{default: 0}; m_fresh = 0; m_cnt = 0;
    end else if (FlushW) begin
      m = '{default: 0}; m_fresh = 0;
    end else if (StallW) begin
      m_fresh = 0;
    end else begin
      m.valid = ValidM; m.regwrite = RegWriteM; m.src = ResultSrcM; m.f3 = Funct3M;
      m.rd = RdM; m.alu = ALUResultM; m.rdata = RdataM; m.pc4 = PCPlus4M; m.csr = CsrDataM;
      m_fresh = ValidM;
      if (ValidM) m_cnt++;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},   64'(ValidW),        64'(m.valid));
    chk({tag, ".we"},      64'(RegWriteW_out), 64'(m.regwrite && m.valid && m.rd != 0));
    chk({tag, ".rd"},      64'(RdW_out),       64'(m.rd));
    chk({tag, ".result"},  64'(ResultW),       64'(model_result()));
    chk({tag, ".retire"},  64'(RetireW),       64'(m.valid && m_fresh));
    chk({tag, ".instret"}, InstretW,           m_cnt);
    chk({tag, ".inst4"},   64'(InstretW4),     m_cnt % 16);
  endtask

  // One clock: model samples the same inputs as the DUT, then outputs settle.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit we, input bit [1:0] src, input bit [2:0] f3,
                       input bit [31:0] alu, input bit [31:0] rdat, input bit [31:0] pc4,
                       input bit [31:0] csr, input bit [4:0] rd);
    ValidM = v; RegWriteM = we; ResultSrcM = src; Funct3M = f3; ALUResultM = alu;
    RdataM = rdat; PCPlus4M = pc4; CsrDataM = csr; RdM = rd;
  endtask

  typedef struct {
    bit        v, we;
    bit [1:0]  src;
    bit [2:0]  f3;
    bit [31:0] alu, rdat, pc4, csr;
    bit [4:0]  rd;
    bit [31:0] exp_res;
    bit        exp_we;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit [31:0] a_alu;
    bit [31:0] b_alu;
    longint unsigned cnt0;
    reset = 1'b1; StallW = 0; FlushW = 0;
    drive(1, 1, 2'b01, 3'b000, 32'h1234_5671, 32'h80F0_7F11, 32'h44, 32'h55, 5'd7);

    // Reset for two cycles with a live instruction on M.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst.valid",   64'(ValidW),        64'd0);
      chk("rst.we",      64'(RegWriteW_out), 64'd0);
      chk("rst.result",  64'(ResultW),       64'd0);
      chk("rst.retire",  64'(RetireW),       64'd0);
      chk("rst.instret", InstretW,           64'd0);
    end
    reset = 1'b0;

    vecs[0]  = '{1,1,2'b01,3'b000,32'h1000_0001,32'h80F0_7F11,0,0,5'd5, 32'h0000_007F,1};
    vecs[1]  = '{1,1,2'b01,3'b000,32'h1000_0002,32'h80F0_7F11,0,0,5'd5, 32'hFFFF_FFF0,1};
    vecs[2]  = '{1,1,2'b01,3'b101,32'h1000_0002,32'h80F0_7F11,0,0,5'd5, 32'h0000_80F0,1};
    vecs[3]  = '{1,1,2'b01,3'b001,32'h1000_0003,32'h80F0_7F11,0,0,5'd5, 32'hFFFF_80F0,1};
    vecs[4]  = '{1,1,2'b01,3'b010,32'h1000_0003,32'h80F0_7F11,0,0,5'd6, 32'h80F0_7F11,1};
    vecs[5]  = '{1,1,2'b01,3'b100,32'h1000_0003,32'h80F0_7F11,0,0,5'd6, 32'h0000_0080,1};
    vecs[6]  = '{1,1,2'b01,3'b000,32'h1000_0003,32'h80F0_7F11,0,0,5'd6, 32'hFFFF_FF80,1};
    vecs[7]  = '{1,1,2'b01,3'b001,32'h1000_0000,32'h80F0_7F11,0,0,5'd6, 32'h0000_7F11,1};
    vecs[8]  = '{1,1,2'b01,3'b110,32'h1000_0001,32'h80F0_7F11,0,0,5'd6, 32'h80F0_7F11,1};
    vecs[9]  = '{1,1,2'b00,3'b000,32'h1234_5678,32'h80F0_7F11,32'hDEAD_BEF0,32'hCAFE_F00D,5'd8, 32'h1234_5678,1};
    vecs[10] = '{1,1,2'b10,3'b000,32'h1234_5678,32'h80F0_7F11,32'hDEAD_BEF0,32'hCAFE_F00D,5'd9, 32'hDEAD_BEF0,1};
    vecs[11] = '{1,1,2'b11,3'b000,32'h1234_5678,32'h80F0_7F11,32'hDEAD_BEF0,32'hCAFE_F00D,5'd31,32'hCAFE_F00D,1};
    vecs[12] = '{1,1,2'b00,3'b000,32'hAAAA_5555,0,0,0,5'd0, 32'hAAAA_5555,0};
    vecs[13] = '{1,0,2'b00,3'b000,32'h5555_AAAA,0,0,0,5'd7, 32'h5555_AAAA,0};

    foreach (vecs[i]) begin
      cnt0 = m_cnt;
      drive(vecs[i].v, vecs[i].we, vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].rdat,
            vecs[i].pc4, vecs[i].csr, vecs[i].rd);
      cycle();
      chk($sformatf("vec%0d.result", i), 64'(ResultW),       64'(vecs[i].exp_res));
      chk($sformatf("vec%0d.we", i),     64'(RegWriteW_out), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d.rd", i),     64'(RdW_out),       64'(vecs[i].rd));
      chk($sformatf("vec%0d.valid", i),  64'(ValidW),        64'd1);
      chk($sformatf("vec%0d.retire", i), 64'(RetireW),       64'd1);
      chk($sformatf("vec%0d.instret", i), InstretW,          cnt0 + 1);
    end

    // Capture A, then stall 3 cycles while B sits on M.
    reset = 1'b1; cycle(); reset = 1'b0;
    a_alu = 32'h1111_2222; b_alu = 32'h3333_4444;
    drive(1, 1, 2'b00, 3'b000, a_alu, 0, 0, 0, 5'd9);
    cycle();
    chk("stallA.result", 64'(ResultW), 64'(a_alu));
    chk("stallA.retire", 64'(RetireW), 64'd1);
    chk("stallA.instret", InstretW, 64'd1);
    drive(1, 1, 2'b00, 3'b000, b_alu, 0, 0, 0, 5'd10);
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall.result",  64'(ResultW),  64'(a_alu));
      chk("stall.rd",      64'(RdW_out),  64'd9);
      chk("stall.valid",   64'(ValidW),   64'd1);
      chk("stall.retire",  64'(RetireW),  64'd0);
      chk("stall.instret", InstretW,      64'd1);
    end
    StallW = 1'b0;
    cycle();
    chk("stallB.result",  64'(ResultW), 64'(b_alu));
    chk("stallB.retire",  64'(RetireW), 64'd1);
    chk("stallB.instret", InstretW,     64'd2);

    // Flush together with stall and a valid M instruction.
    FlushW = 1'b1; StallW = 1'b1;
    cycle();
    chk("flush.valid",   64'(ValidW),        64'd0);
    chk("flush.we",      64'(RegWriteW_out), 64'd0);
    chk("flush.retire",  64'(RetireW),       64'd0);
    chk("flush.instret", InstretW,           64'd2);
    FlushW = 1'b0; StallW = 1'b0;
    check_model("post_flush");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      StallW = ($urandom_range(0, 4) == 0);
      FlushW = ($urandom_range(0, 9) == 0);
      cycle();
      check_model("rand");
    end
    StallW = 0; FlushW = 0;

    // 4-bit counter wraps from 15 to 0 on the 16th retirement.
    reset = 1'b1; cycle(); reset = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 32'h77, 0, 0, 0, 5'd3);
    for (int i = 0; i < 15; i++) cycle();
    chk("wrap.pre4",  64'(InstretW4), 64'd15);
    cycle();
    chk("wrap.post4", 64'(InstretW4), 64'd0);
    chk("wrap.post64", InstretW,      64'd16);
    check_model("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
